// File: rtl/tag_ctrl_pkg.sv
// Shared types for the tag RAM controller: FSM states, stored tag entry layout
// and the entry parity helper. TAG_PARITY_EN adds an even-parity bit as entry LSB.
package tag_ctrl_pkg;

    localparam int unsigned TC_LINES = 512;
    localparam int unsigned TAG_W    = 20;
`ifdef TAG_PARITY_EN
    localparam int unsigned EW       = TAG_W + 2;
`else
    localparam int unsigned EW       = TAG_W + 1;
`endif

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } tag_ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
`ifdef TAG_PARITY_EN
        logic             parity;
`endif
    } tag_entry_t;

    // Even parity over {valid, tag}: an all-zero entry carries parity 0.
    function automatic logic tag_parity(input logic valid, input logic [TAG_W-1:0] tag);
        return ^{valid, tag};
    endfunction

endpackage : tag_ctrl_pkg

// File: rtl/tag_ctrl.sv
// Initiator for the dual-port tag bank: clears all lines after reset, serves
// lookups on port A and fill/invalidate updates on port B, and sweeps the bank
// on a flush request. Optional macro: TAG_PARITY_EN (entry parity check).
module tag_ctrl
    import tag_ctrl_pkg::*;
#(
    parameter  int unsigned LINES = TC_LINES,
    localparam int unsigned AW    = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    output logic             lookup_ready,
    input  logic [AW-1:0]    lookup_line,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_parity_err,
    input  logic             update_valid,
    output logic             update_ready,
    input  logic [AW-1:0]    update_line,
    input  logic [TAG_W-1:0] update_tag,
    input  logic             update_inv,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             init_done,
    output logic             bank_en_a,
    output logic             bank_wen_a,
    output logic [AW-1:0]    bank_addr_a,
    output logic [EW-1:0]    bank_wdata_a,
    input  logic [EW-1:0]    bank_rdata_a,
    output logic             bank_en_b,
    output logic             bank_wen_b,
    output logic [AW-1:0]    bank_addr_b,
    output logic [EW-1:0]    bank_wdata_b
);

    tag_ctrl_state_t  state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic             flush_busy_q, flush_busy_d;

    logic             resp_valid_q, resp_valid_d;
    logic             fwd_q, fwd_d;
    tag_entry_t       fwd_entry_q, fwd_entry_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             run_c;
    logic             sweep_last_c;
    logic             lookup_fire_c;
    logic             update_fire_c;
    tag_entry_t       upd_entry_c;
    tag_entry_t       rd_entry_c;
    logic             tag_match_c;
    logic             perr_c;

    // Control state, sweep counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            flush_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    // Next state: sweep lines 0..LINES-1 in INIT/FLUSH, enter FLUSH on request in RUN.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        sweep_last_c = (cnt_q == AW'(LINES - 1));
        unique case (state_q)
            INIT: begin
                if (sweep_last_c) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (sweep_last_c) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        flush_busy_d = (state_d == FLUSH);
    end

    // Handshakes and the entry an update would write.
    always_comb begin
        run_c         = (state_q == RUN);
        lookup_fire_c = run_c && lookup_valid;
        update_fire_c = run_c && update_valid;
        upd_entry_c   = '0;
        upd_entry_c.valid = ~update_inv;
        upd_entry_c.tag   = update_tag;
`ifdef TAG_PARITY_EN
        upd_entry_c.parity = tag_parity(~update_inv, update_tag);
`endif
    end

    // Bank port drive: A reads for lookups, B writes sweep zeros or updates.
    always_comb begin
        bank_en_a    = lookup_fire_c;
        bank_wen_a   = 1'b0;
        bank_addr_a  = lookup_line;
        bank_wdata_a = '0;
        bank_en_b    = 1'b0;
        bank_wen_b   = 1'b0;
        bank_addr_b  = cnt_q;
        bank_wdata_b = '0;
        if (run_c) begin
            bank_en_b    = update_fire_c;
            bank_wen_b   = update_fire_c;
            bank_addr_b  = update_line;
            bank_wdata_b = EW'(upd_entry_c);
        end else begin
            bank_en_b    = 1'b1;
            bank_wen_b   = 1'b1;
        end
    end

    // Lookup tracking: capture tag, and forward a same-cycle same-line update.
    always_comb begin
        resp_valid_d = lookup_fire_c;
        fwd_d        = lookup_fire_c && update_fire_c && (lookup_line == update_line);
        fwd_entry_d  = fwd_entry_q;
        tag_d        = tag_q;
        if (lookup_fire_c) begin
            fwd_entry_d = upd_entry_c;
            tag_d       = lookup_tag;
        end
    end

    // Lookup pipeline registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_entry_q  <= '0;
            tag_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            fwd_q        <= fwd_d;
            fwd_entry_q  <= fwd_entry_d;
            tag_q        <= tag_d;
        end
    end

    // Result: compare the read (or forwarded) entry against the registered tag.
    always_comb begin
        rd_entry_c  = fwd_q ? fwd_entry_q : tag_entry_t'(bank_rdata_a);
        tag_match_c = rd_entry_c.valid && (rd_entry_c.tag == tag_q);
`ifdef TAG_PARITY_EN
        perr_c      = resp_valid_q &&
                      (rd_entry_c.parity != tag_parity(rd_entry_c.valid, rd_entry_c.tag));
`else
        perr_c      = 1'b0;
`endif
        resp_hit        = resp_valid_q && tag_match_c && !perr_c;
        resp_parity_err = perr_c;
    end

    assign resp_valid   = resp_valid_q;
    assign lookup_ready = run_c;
    assign update_ready = run_c;
    assign init_done    = init_done_q;
    assign flush_busy   = flush_busy_q;

endmodule : tag_ctrl
